// File: rtl/song_menu_ctrl.sv
// Song selection menu controller.
// Four raw buttons are synchronized and debounced. The press events then drive a
// MENU/START/PLAYING state machine, and every output comes straight from a flop.
module song_menu_ctrl #(
  parameter int unsigned NUM_SONGS       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_confirm,
  input  logic       btn_back,
  input  logic       song_done,
  output logic       menu_enabled,
  output logic [1:0] song,
  output logic       play_start,
  output logic       playing
);

  localparam int unsigned NumBtn   = 4;
  localparam int unsigned BtnUp    = 0;
  localparam int unsigned BtnDown  = 1;
  localparam int unsigned BtnConf  = 2;
  localparam int unsigned BtnBack  = 3;
  localparam logic [19:0] DebLimit = 20'(DEBOUNCE_CYCLES);
  localparam logic [1:0]  LastSong = 2'(NUM_SONGS - 1);

  typedef enum logic [1:0] {StMenu, StStart, StPlaying} state_e;

  state_e              state_q;
  logic [NumBtn-1:0]   btn_raw;
  logic [NumBtn-1:0]   sync1_q;
  logic [NumBtn-1:0]   sync2_q;
  logic [NumBtn-1:0]   deb_q;
  logic [NumBtn-1:0]   press_q;
  logic [19:0]         cnt_q [NumBtn];

  assign btn_raw = {btn_back, btn_confirm, btn_down, btn_up};

  // Two-flop synchronizer on every raw button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  // The press pulse is registered together with the accepted 0->1 level change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumBtn; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] + 20'd1 == DebLimit) begin
          deb_q[i]   <= sync2_q[i];
          cnt_q[i]   <= '0;
          press_q[i] <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 20'd1;
        end
      end
    end
  end

  // Menu state machine with registered outputs. song only moves while in MENU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StMenu;
      song         <= '0;
      menu_enabled <= 1'b1;
      play_start   <= 1'b0;
      playing      <= 1'b0;
    end else begin
      case (state_q)
        StMenu: begin
          if (press_q[BtnConf]) begin
            state_q      <= StStart;
            menu_enabled <= 1'b0;
            play_start   <= 1'b1;
          end else if (press_q[BtnUp] && !press_q[BtnDown]) begin
            song <= (song == LastSong) ? 2'd0 : song + 2'd1;
          end else if (press_q[BtnDown] && !press_q[BtnUp]) begin
            song <= (song == 2'd0) ? LastSong : song - 2'd1;
          end
        end
        StStart: begin
          state_q    <= StPlaying;
          play_start <= 1'b0;
          playing    <= 1'b1;
        end
        StPlaying: begin
          if (song_done || press_q[BtnBack]) begin
            state_q      <= StMenu;
            playing      <= 1'b0;
            menu_enabled <= 1'b1;
          end
        end
        default: begin
          state_q      <= StMenu;
          menu_enabled <= 1'b1;
          play_start   <= 1'b0;
          playing      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_menu_ctrl.sv
// Self-checking bench for song_menu_ctrl with a behavioural reference model.
module tb_song_menu_ctrl;

  localparam int unsigned NUM = 4;
  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_confirm = 1'b0;
  logic       btn_back = 1'b0;
  logic       song_done = 1'b0;
  logic       menu_enabled;
  logic [1:0] song;
  logic       play_start;
  logic       playing;

  int pass_cnt = 0;
  int total_cnt = 0;

  song_menu_ctrl #(
    .NUM_SONGS      (NUM),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_confirm (btn_confirm),
    .btn_back    (btn_back),
    .song_done   (song_done),
    .menu_enabled(menu_enabled),
    .song        (song),
    .play_start  (play_start),
    .playing     (playing)
  );

  always #5 clk = ~clk;

  // Reference model: raw values two edges old are what the debouncer sees; a level
  // flips after DEB consecutive differing samples; a rising flip is a press that the
  // menu acts on one edge later. Mode 0 = menu, 1 = start, 2 = playing.
  logic [3:0]  m_d1, m_d2, m_lvl, m_ev;
  int unsigned m_run [4];
  int          m_mode;
  int          m_song;

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_ev = '0;
    for (int b = 0; b < 4; b++) m_run[b] = 0;
    m_mode = 0;
    m_song = 0;
  endtask

  task automatic model_edge(input logic [3:0] raw, input logic done);
    logic seen;
    case (m_mode)
      0: begin
        if (m_ev[2]) m_mode = 1;
        else if (m_ev[0] && !m_ev[1]) m_song = (m_song + 1) % NUM;
        else if (m_ev[1] && !m_ev[0]) m_song = (m_song + NUM - 1) % NUM;
      end
      1: m_mode = 2;
      default: if (done || m_ev[3]) m_mode = 0;
    endcase
    for (int b = 0; b < 4; b++) begin
      seen = m_d2[b];
      m_ev[b] = 1'b0;
      if (seen != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_lvl[b] = seen;
          m_run[b] = 0;
          m_ev[b] = seen;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = raw;
  endtask

  function automatic logic [4:0] exp_vec();
    return {m_mode == 0, 2'(m_song), m_mode == 1, m_mode == 2};
  endfunction

  function automatic logic [4:0] obs_vec();
    return {menu_enabled, song, play_start, playing};
  endfunction

  // One clock edge; inputs are stable across it and the model sees the same values.
  task automatic step();
    logic [3:0] raw;
    logic       d;
    raw = {btn_back, btn_confirm, btn_down, btn_up};
    d   = song_done;
    @(posedge clk);
    #1;
    if (rst_n) model_edge(raw, d);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_up = v;
      1: btn_down = v;
      2: btn_confirm = v;
      default: btn_back = v;
    endcase
  endtask

  // Clean press: hold long enough to register, then release and let it settle.
  task automatic press_btn(input int b);
    set_btn(b, 1'b1);
    repeat (7) step();
    set_btn(b, 1'b0);
    repeat (8) step();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if (obs_vec() !== 5'b1_00_0_0)
      $display("FAIL reset_async: outputs=%b expected %b", obs_vec(), 5'b1_00_0_0);
    else pass_cnt++;
    repeat (2) step();
    total_cnt++;
    if (obs_vec() !== exp_vec())
      $display("FAIL reset_held: outputs=%b expected %b", obs_vec(), exp_vec());
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_up_wrap();
    for (int i = 0; i < 4; i++) begin
      set_btn(0, 1'b1);
      repeat (6) step();
      total_cnt++;
      if (song !== 2'(i)) $display("FAIL up_early_%0d: song=%0d expected %0d", i, song, i);
      else pass_cnt++;
      step();
      total_cnt++;
      if (song !== 2'((i + 1) % 4))
        $display("FAIL up_at7_%0d: song=%0d expected %0d", i, song, (i + 1) % 4);
      else pass_cnt++;
      set_btn(0, 1'b0);
      repeat (8) step();
      total_cnt++;
      if (obs_vec() !== exp_vec())
        $display("FAIL up_settle_%0d: outputs=%b expected %b", i, obs_vec(), exp_vec());
      else pass_cnt++;
    end
  endtask

  task automatic test_down_wrap();
    press_btn(1);
    total_cnt++;
    if (song !== 2'd3) $display("FAIL down_wrap: song=%0d expected 3", song);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    logic [1:0] saved;
    saved = song;
    for (int p = 0; p < 5; p++) begin
      set_btn(0, 1'b1);
      repeat (3) step();
      set_btn(0, 1'b0);
      step();
    end
    repeat (8) step();
    total_cnt++;
    if (song !== saved) $display("FAIL glitch_reject: song=%0d expected %0d", song, saved);
    else pass_cnt++;
    set_btn(0, 1'b1);
    repeat (5) step();
    set_btn(0, 1'b0);
    repeat (10) step();
    total_cnt++;
    if (song !== saved + 2'd1)
      $display("FAIL glitch_clean5: song=%0d expected %0d", song, saved + 2'd1);
    else pass_cnt++;
  endtask

  task automatic test_play();
    while (m_song != 2) press_btn(0);
    set_btn(2, 1'b1);
    repeat (6) step();
    total_cnt++;
    if ({menu_enabled, play_start} !== 2'b10)
      $display("FAIL confirm_early: menu/start=%b expected 10", {menu_enabled, play_start});
    else pass_cnt++;
    step();
    total_cnt++;
    if (obs_vec() !== 5'b0_10_1_0)
      $display("FAIL start_cycle: outputs=%b expected %b", obs_vec(), 5'b0_10_1_0);
    else pass_cnt++;
    step();
    total_cnt++;
    if (obs_vec() !== 5'b0_10_0_1)
      $display("FAIL playing_entry: outputs=%b expected %b", obs_vec(), 5'b0_10_0_1);
    else pass_cnt++;
    set_btn(2, 1'b0);
    repeat (8) step();
    press_btn(0);
    total_cnt++;
    if (obs_vec() !== 5'b0_10_0_1)
      $display("FAIL up_in_play: outputs=%b expected %b", obs_vec(), 5'b0_10_0_1);
    else pass_cnt++;
    song_done = 1'b1;
    step();
    song_done = 1'b0;
    total_cnt++;
    if (obs_vec() !== 5'b1_10_0_0)
      $display("FAIL done_return: outputs=%b expected %b", obs_vec(), 5'b1_10_0_0);
    else pass_cnt++;
    repeat (10) step();
    total_cnt++;
    if (song !== 2'd2) $display("FAIL no_queue: song=%0d expected 2", song);
    else pass_cnt++;
  endtask

  task automatic test_back_and_done();
    press_btn(2);
    set_btn(3, 1'b1);
    repeat (6) step();
    song_done = 1'b1;
    step();
    song_done = 1'b0;
    total_cnt++;
    if (obs_vec() !== 5'b1_10_0_0)
      $display("FAIL back_done_same: outputs=%b expected %b", obs_vec(), 5'b1_10_0_0);
    else pass_cnt++;
    set_btn(3, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      total_cnt++;
      if (obs_vec() !== 5'b1_10_0_0)
        $display("FAIL back_done_quiet_%0d: outputs=%b expected %b", c, obs_vec(), 5'b1_10_0_0);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    press_btn(2);
    total_cnt++;
    if (playing !== 1'b1) $display("FAIL pre_reset_play: playing=%b expected 1", playing);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if (obs_vec() !== 5'b1_00_0_0)
      $display("FAIL reset_mid_play: outputs=%b expected %b", obs_vec(), 5'b1_00_0_0);
    else pass_cnt++;
    set_btn(0, 1'b1);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (6) step();
    total_cnt++;
    if (song !== 2'd0) $display("FAIL held_early: song=%0d expected 0", song);
    else pass_cnt++;
    step();
    total_cnt++;
    if (song !== 2'd1) $display("FAIL held_through_reset: song=%0d expected 1", song);
    else pass_cnt++;
    repeat (10) step();
    total_cnt++;
    if (song !== 2'd1) $display("FAIL held_single_event: song=%0d expected 1", song);
    else pass_cnt++;
    set_btn(0, 1'b0);
    repeat (8) step();
  endtask

  task automatic test_same_cycle();
    btn_up = 1'b1;
    btn_down = 1'b1;
    repeat (7) step();
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (8) step();
    total_cnt++;
    if (obs_vec() !== 5'b1_01_0_0)
      $display("FAIL up_down_same: outputs=%b expected %b", obs_vec(), 5'b1_01_0_0);
    else pass_cnt++;
    btn_up = 1'b1;
    btn_confirm = 1'b1;
    repeat (7) step();
    total_cnt++;
    if (obs_vec() !== 5'b0_01_1_0)
      $display("FAIL confirm_up_same: outputs=%b expected %b", obs_vec(), 5'b0_01_1_0);
    else pass_cnt++;
    btn_up = 1'b0;
    btn_confirm = 1'b0;
    repeat (8) step();
    song_done = 1'b1;
    step();
    song_done = 1'b0;
    total_cnt++;
    if (obs_vec() !== 5'b1_01_0_0)
      $display("FAIL confirm_up_return: outputs=%b expected %b", obs_vec(), 5'b1_01_0_0);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int hold [4];
    for (int b = 0; b < 4; b++) hold[b] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          set_btn(b, 1'($urandom_range(0, 1)));
          hold[b] = $urandom_range(1, 9);
        end else begin
          hold[b]--;
        end
      end
      song_done = ($urandom_range(0, 9) == 0);
      step();
      total_cnt++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random_%0d: outputs=%b expected %b", c, obs_vec(), exp_vec());
      else pass_cnt++;
    end
    song_done = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_glitch();
    test_play();
    test_back_and_done();
    test_reset_mid();
    test_same_cycle();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/song_menu_ctrl.md
SONG_MENU_CTRL -- requirements
Module: song_menu_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SONGS, default 4, giving the number of selectable songs (legal range 2..4).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the consecutive stable clk cycles (10 ms at 100 MHz) required to accept a button level change (legal range 1..2^20-1).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 btn_up  input  1  raw, asynchronous, bouncy button; selects the next song.
REQ-006 btn_down  input  1  raw, asynchronous, bouncy button; selects the previous song.
REQ-007 btn_confirm  input  1  raw, asynchronous, bouncy button; starts the selected song.
REQ-008 btn_back  input  1  raw, asynchronous, bouncy button; aborts play and returns to the menu.
REQ-009 song_done  input  1  synchronous single-cycle pulse from the player at end of song.
REQ-010 menu_enabled  output  1  registered; high while the menu is shown, feeding the menu renderer.
REQ-011 song  output  2  registered; selected song index, 0..NUM_SONGS-1.
REQ-012 play_start  output  1  registered; single-cycle pulse to the player.
REQ-013 playing  output  1  registered; high while a song plays.

Function
REQ-014 Each btn_* SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-015 Each synchronized button SHALL have a debounced level register and a counter; the counter clears whenever the synchronized value equals the debounced level.
REQ-016 The counter SHALL increment while the two values differ; when it reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter clears.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES SHALL NOT change the debounced level.
REQ-018 A press event SHALL be a one-cycle pulse on the debounced 0->1 transition; a release SHALL generate no event.
REQ-019 Latency from a clean raw rise to the press event SHALL be exactly 2+DEBOUNCE_CYCLES cycles.
REQ-020 Latency from a press event to the registered output change SHALL be one cycle.
REQ-021 The FSM SHALL have three states: MENU, START and PLAYING.
REQ-022 MENU, priority order: confirm event -> START with song frozen; else up and down events in the same cycle -> no change; else up -> song+1, NUM_SONGS-1 wraps to 0; else down -> song-1, 0 wraps to NUM_SONGS-1.
REQ-023 START SHALL last exactly one cycle, then go to PLAYING unconditionally; buttons and song_done are ignored in START.
REQ-024 PLAYING: song_done pulse or back event -> MENU; if both occur in the same cycle, a single transition to MENU occurs.
REQ-025 In PLAYING, up, down and confirm events SHALL be discarded and SHALL NOT be queued.
REQ-026 song_done and back events in MENU SHALL be ignored.
REQ-027 The song output SHALL change only in MENU and SHALL keep its value across PLAYING and the return to MENU.
REQ-028 menu_enabled SHALL be 1 exactly while the state is MENU.
REQ-029 play_start SHALL be 1 exactly during the START cycle.
REQ-030 playing SHALL be 1 exactly while the state is PLAYING.
REQ-031 All outputs SHALL be driven from flops, with no combinational path from inputs to outputs.

Reset
REQ-032 While rst_n=0: state=MENU, song=0, menu_enabled=1, play_start=0, playing=0, all synchronizer flops, debounced levels and counters =0.
REQ-033 Reset asserted mid-operation, including during START or PLAYING, SHALL force the REQ-032 values immediately, without waiting for clk.
REQ-034 A button held high through reset release SHALL produce exactly one press event, 2+DEBOUNCE_CYCLES cycles after release.

Verification (DEBOUNCE_CYCLES=4, NUM_SONGS=4)
REQ-035 Reset, then 3 clean btn_up presses -> song goes 0->1->2->3, each change 7 cycles after its raw rise; a 4th press wraps song to 0.
REQ-036 From song=0, one btn_down press -> song=3.
REQ-037 btn_up toggling with 3-cycle pulses and 1-cycle gaps -> song unchanged; a held 5-cycle clean pulse -> exactly +1.
REQ-038 song=2, btn_confirm press -> play_start=1 for one cycle, then playing=1 and menu_enabled=0; btn_up pressed during play -> song stays 2; song_done pulse -> menu_enabled=1 next cycle, song=2.
REQ-039 In PLAYING, a btn_back press in the same cycle as a song_done pulse -> single return to MENU with no extra play_start; rst_n dropped during PLAYING -> playing=0 and song=0 immediately.
REQ-040 Up and down events aligned in the same cycle in MENU -> song unchanged; confirm and up in the same cycle -> START with song unchanged.
